mmio_initiator: RTL and testbench
=================================

# mmio_initiator

Synthesizable CCI-P MMIO requester: the host-side counterpart of the AFU MMIO responder. It accepts single 64-bit read/write commands on a simple valid/ready port and drives MMIO request strobes, address, TID and write data toward a responder. It matches read completions by TID and returns data or a timeout. It serves as an on-chip self-test master and as the bench driver for AFU register blocks.

## Interface
Parameters:
- TID_W, 9, transaction ID width; matches the CCI-P MMIO tid field.
- TIMEOUT, 256, number of wait cycles before an outstanding read is abandoned; legal range 2..65535.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  16  MMIO DWORD address; must be even for a 64-bit access.
- cmd_wdata  in  64  write data.
- req_rd_valid  out  1  one-cycle MMIO read request strobe.
- req_wr_valid  out  1  one-cycle MMIO write request strobe.
- req_addr  out  16  request address.
- req_tid  out  TID_W  request TID.
- req_length  out  2  fixed at 2'b01, meaning 8 B.
- req_data  out  64  write data; 0 for reads.
- cpl_valid  in  1  read completion strobe (the responder's c2 mmioRdValid).
- cpl_tid  in  TID_W  completion TID.
- cpl_data  in  64  completion data.
- rsp_valid  out  1  one-cycle command-done strobe.
- rsp_rdata  out  64  read data, or the fill value on error or timeout.
- rsp_err  out  1  command rejected because the address is misaligned.
- rsp_timeout  out  1  read timed out.
- stray_cnt  out  8  saturating count of unmatched completions.

## Operation
- FSM states are IDLE, ISSUE, WAIT_RD and RESP.
  - cmd_ready = (state == IDLE).
- IDLE: on cmd_valid, latch cmd_wr, cmd_addr and cmd_wdata.
  - If cmd_addr[0] == 1, go to RESP with err set.
  - Otherwise go to ISSUE.
- ISSUE: for exactly one cycle, drive req_wr_valid or req_rd_valid together with the latched fields.
  - Write: go to RESP.
  - Read: drive req_tid = tid_ctr, then go to WAIT_RD.
- WAIT_RD: a match is cpl_valid && cpl_tid == outstanding TID.
  - On a match, latch cpl_data and go to RESP.
  - On cpl_valid with a different TID, increment stray_cnt.
  - The timeout counter increments on every non-matching cycle.
- RESP: rsp_valid = 1 for one cycle, then return to IDLE. Response fields:
  - Write: rdata = 0.
  - Read: rdata = completion data.
  - Misaligned: rsp_err = 1, rdata = 64'hFFFF_FFFF_FFFF_FFFF.
  - Timeout: rsp_timeout = 1, rdata = all-ones.
- tid_ctr increments after each issued read and wraps from 2^TID_W-1 to 0. Writes and rejected commands do not consume a TID.
- stray_cnt also increments on any cpl_valid received outside WAIT_RD. It saturates at 255.
- When a match and timeout expiry occur in the same cycle, the match wins.

## Timing
- Reset values: state IDLE, tid_ctr 0, stray_cnt 0, and all outputs 0 except cmd_ready, which is 1 in IDLE.
- The command is accepted at cycle T.
  - Request strobe at T+1.
  - Write: rsp_valid at T+2.
  - Misaligned: rsp_valid at T+1, and no request strobe is issued.
- Read latency:
  - Completions are sampled from T+2 onward; a completion at T+1 is treated as stray.
  - A match at cycle C produces rsp_valid at C+1.
  - With no match, rsp_valid (timeout) is at T+2+TIMEOUT.
- Back-to-back commands: cmd_ready reasserts in the cycle after rsp_valid, so one command is in flight at most.
- Reset mid-operation abandons the outstanding read and returns the block to IDLE. A late completion after reset counts as stray.
- All req_* and rsp_* outputs are registered, with no combinational path from cmd_* or cpl_*.

## Configuration
- MMIO_INIT_TIMEOUT_EN
  - Defined: the timeout counter and timeout exit from WAIT_RD are present.
  - Undefined: WAIT_RD waits indefinitely for a match, rsp_timeout is tied to 0, and TIMEOUT is ignored.

## Test plan
- Write: cmd_wr=1, cmd_addr=0x0020, cmd_wdata=0xDEADBEEF_CAFEF00D at T.
  - Required: req_wr_valid=1 at T+1 with that addr/data and req_length=01.
  - Required: rsp_valid at T+2, rsp_err=0.
- Read 0x0000 with a responder model that replies 1 cycle after the request using tid 0 and data 0x1000_0100_0000_0000.
  - Required: req_tid=0, rsp_valid at T+3, rsp_rdata equal to that data.
- Two reads, with a stray completion tid=5 injected during the second wait.
  - Required: request TIDs are 0 and then 1; the stray is ignored; stray_cnt=1; the second read returns its correct data.
- Read with no completion, TIMEOUT=16, macro defined.
  - Required: rsp_valid at T+18, rsp_timeout=1, rsp_rdata all-ones.
  - Required: a later completion with tid 0 increments stray_cnt.
- Misaligned read at cmd_addr=0x0021.
  - Required: no req strobe, rsp_valid at T+1 with rsp_err=1, tid_ctr unchanged.
- Assert rst during WAIT_RD, then deliver the matching completion 2 cycles after reset release.
  - Required: no rsp_valid, stray_cnt=1, next read uses tid 0.

Source files
------------

// File: rtl/mmio_initiator_if.sv
// MMIO initiator bus bundle: command port, request strobes, read completions,
// response port and the stray-completion counter.
// master: the initiator's view. slave: the command source / responder side.
interface mmio_initiator_if #(
    parameter int unsigned TID_W = 9
);
    // Command port
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_wr;
    logic [15:0]      cmd_addr;
    logic [63:0]      cmd_wdata;
    // MMIO request toward the responder
    logic             req_rd_valid;
    logic             req_wr_valid;
    logic [15:0]      req_addr;
    logic [TID_W-1:0] req_tid;
    logic [1:0]       req_length;
    logic [63:0]      req_data;
    // Read completion from the responder
    logic             cpl_valid;
    logic [TID_W-1:0] cpl_tid;
    logic [63:0]      cpl_data;
    // Command response
    logic             rsp_valid;
    logic [63:0]      rsp_rdata;
    logic             rsp_err;
    logic             rsp_timeout;
    logic [7:0]       stray_cnt;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
        input  cpl_valid, cpl_tid, cpl_data,
        output cmd_ready,
        output req_rd_valid, req_wr_valid, req_addr, req_tid, req_length, req_data,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout, stray_cnt
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
        output cpl_valid, cpl_tid, cpl_data,
        input  cmd_ready,
        input  req_rd_valid, req_wr_valid, req_addr, req_tid, req_length, req_data,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout, stray_cnt
    );
endinterface

// File: rtl/mmio_initiator.sv
// CCI-P MMIO requester: issues single 64-bit reads/writes, matches read
// completions by TID and returns data, an alignment error or a timeout.
// Optional feature macro: MMIO_INIT_TIMEOUT_EN enables the read timeout;
// without it WAIT_RD waits for a match indefinitely and rsp_timeout is 0.
module mmio_initiator #(
    parameter int unsigned TID_W   = 9,
    parameter int unsigned TIMEOUT = 256
) (
    input logic              clk,
    input logic              rst,
    mmio_initiator_if.master bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRd, StResp} state_e;

    localparam logic [63:0] FillVal = 64'hFFFF_FFFF_FFFF_FFFF;

    state_e           state_q, state_d;
    logic             wr_q, wr_d;
    logic [15:0]      addr_q, addr_d;
    logic [63:0]      wdata_q, wdata_d;
    logic [TID_W-1:0] tid_ctr_q, tid_ctr_d;
    logic [TID_W-1:0] out_tid_q, out_tid_d;
    logic [63:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [7:0]       stray_q, stray_d;
    logic             cpl_match;

`ifdef MMIO_INIT_TIMEOUT_EN
    localparam logic [15:0] ToLast = 16'(TIMEOUT - 1);

    logic [15:0] to_cnt_q, to_cnt_d;
    logic        to_q, to_d;
    logic        to_expire;

    // Last non-matching wait cycle before abandoning the read; a match wins.
    assign to_expire = (state_q == StWaitRd) && !cpl_match && (to_cnt_q == ToLast);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Only a completion seen in WAIT_RD with the outstanding TID is ours.
    assign cpl_match = bus.cpl_valid && (state_q == StWaitRd) && (bus.cpl_tid == out_tid_q);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    state_d = bus.cmd_addr[0] ? StResp : StIssue;
                end
            end
            StIssue:  state_d = wr_q ? StResp : StWaitRd;
            StWaitRd: begin
                if (cpl_match) begin
                    state_d = StResp;
                end
`ifdef MMIO_INIT_TIMEOUT_EN
                else if (to_expire) begin
                    state_d = StResp;
                end
`endif
            end
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath next-state: command latch, TID allocation, response capture.
    always_comb begin
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tid_ctr_d = tid_ctr_q;
        out_tid_d = out_tid_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        stray_d   = stray_q;
`ifdef MMIO_INIT_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        to_d      = to_q;
`endif
        // Any completion that is not the awaited one is stray; saturate at 255.
        if (bus.cpl_valid && !cpl_match && (stray_q != 8'hFF)) begin
            stray_d = stray_q + 8'd1;
        end
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    wr_d    = bus.cmd_wr;
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    err_d   = bus.cmd_addr[0];
                    rdata_d = bus.cmd_addr[0] ? FillVal : 64'h0;
`ifdef MMIO_INIT_TIMEOUT_EN
                    to_d    = 1'b0;
`endif
                end
            end
            StIssue: begin
                // Only reads consume a TID.
                if (!wr_q) begin
                    out_tid_d = tid_ctr_q;
                    tid_ctr_d = tid_ctr_q + TID_W'(1);
                end
`ifdef MMIO_INIT_TIMEOUT_EN
                to_cnt_d = 16'h0;
`endif
            end
            StWaitRd: begin
                if (cpl_match) begin
                    rdata_d = bus.cpl_data;
                end
`ifdef MMIO_INIT_TIMEOUT_EN
                else if (to_expire) begin
                    rdata_d = FillVal;
                    to_d    = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
`endif
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= 1'b0;
            addr_q    <= 16'h0;
            wdata_q   <= 64'h0;
            tid_ctr_q <= '0;
            out_tid_q <= '0;
            rdata_q   <= 64'h0;
            err_q     <= 1'b0;
            stray_q   <= 8'h0;
`ifdef MMIO_INIT_TIMEOUT_EN
            to_cnt_q  <= 16'h0;
            to_q      <= 1'b0;
`endif
        end else begin
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tid_ctr_q <= tid_ctr_d;
            out_tid_q <= out_tid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            stray_q   <= stray_d;
`ifdef MMIO_INIT_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
            to_q      <= to_d;
`endif
        end
    end

    assign bus.req_length = 2'b01;
    assign bus.stray_cnt  = stray_q;

    // Outputs decoded from registered state only; no path from cmd_* or cpl_*.
    always_comb begin
        bus.cmd_ready    = 1'b0;
        bus.req_rd_valid = 1'b0;
        bus.req_wr_valid = 1'b0;
        bus.req_addr     = 16'h0;
        bus.req_tid      = '0;
        bus.req_data     = 64'h0;
        bus.rsp_valid    = 1'b0;
        bus.rsp_rdata    = 64'h0;
        bus.rsp_err      = 1'b0;
        bus.rsp_timeout  = 1'b0;
        unique case (state_q)
            StIdle:  bus.cmd_ready = 1'b1;
            StIssue: begin
                bus.req_wr_valid = wr_q;
                bus.req_rd_valid = !wr_q;
                bus.req_addr     = addr_q;
                bus.req_tid      = wr_q ? '0 : tid_ctr_q;
                bus.req_data     = wr_q ? wdata_q : 64'h0;
            end
            StResp: begin
                bus.rsp_valid   = 1'b1;
                bus.rsp_rdata   = rdata_q;
                bus.rsp_err     = err_q;
`ifdef MMIO_INIT_TIMEOUT_EN
                bus.rsp_timeout = to_q;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mmio_initiator.sv
// Directed + randomized bench for mmio_initiator. Expected TIDs, stray counts,
// latencies and response data come from a small transaction-level model.
module tb_mmio_initiator;

    localparam int unsigned TidW       = 9;
    localparam int unsigned TimeoutCyc = 16;
    localparam int          TidMod     = 1 << TidW;
    localparam logic [63:0] Ones       = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mmio_initiator_if #(.TID_W(TidW)) bus ();

    mmio_initiator #(
        .TID_W  (TidW),
        .TIMEOUT(TimeoutCyc)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int exp_tid  = 0;   // next TID the model expects to be issued
    int exp_stray = 0;  // model of stray_cnt

`define CHECK(tag, obs, want) \
    begin \
        n_assert++; \
        assert ((obs) === (want)) else begin \
            n_fail++; \
            $error("FAIL %s: got %0h, want %0h", tag, (obs), (want)); \
        end \
    end

    task automatic bump_stray();
        exp_stray = (exp_stray >= 255) ? 255 : exp_stray + 1;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after rsp.
    task automatic do_write(input logic [15:0] addr, input logic [63:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = data;
        @(negedge clk);  // T+1
        bus.cmd_valid = 1'b0;
        `CHECK("wr_strobe", {bus.req_wr_valid, bus.req_rd_valid, bus.rsp_valid, bus.cmd_ready}, 4'b1000)
        `CHECK("wr_addr", bus.req_addr, addr)
        `CHECK("wr_data", bus.req_data, data)
        `CHECK("wr_length", bus.req_length, 2'b01)
        @(negedge clk);  // T+2
        `CHECK("wr_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.req_wr_valid}, 4'b1000)
        `CHECK("wr_rdata", bus.rsp_rdata, 64'h0)
        @(negedge clk);
        `CHECK("wr_idle", {bus.cmd_ready, bus.rsp_valid}, 2'b10)
    endtask

    task automatic do_misaligned(input logic [15:0] addr, input logic wr);
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = {$urandom, $urandom};
        @(negedge clk);  // T+1
        bus.cmd_valid = 1'b0;
        `CHECK("mis_nostrobe", {bus.req_rd_valid, bus.req_wr_valid}, 2'b00)
        `CHECK("mis_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 3'b110)
        `CHECK("mis_rdata", bus.rsp_rdata, Ones)
        @(negedge clk);
        `CHECK("mis_idle", {bus.cmd_ready, bus.rsp_valid}, 2'b10)
    endtask

    // Issues a read and returns at T+1 after checking the request.
    task automatic start_read(input logic [15:0] addr, output int tid);
        tid = exp_tid;
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = {$urandom, $urandom};
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        `CHECK("rd_strobe", {bus.req_rd_valid, bus.req_wr_valid, bus.rsp_valid, bus.cmd_ready}, 4'b1000)
        `CHECK("rd_tid", bus.req_tid, TidW'(tid))
        `CHECK("rd_addr", bus.req_addr, addr)
        `CHECK("rd_data_zero", bus.req_data, 64'h0)
        `CHECK("rd_length", bus.req_length, 2'b01)
        exp_tid = (exp_tid + 1) % TidMod;
    endtask

    // Responder replies 'delay' cycles after the request; optional stray
    // completion 'stray_at' cycles after the request (-1 = none).
    task automatic do_read(input logic [15:0] addr, input int delay, input logic [63:0] data,
                           input int stray_at, input int stray_tid);
        int tid;
        start_read(addr, tid);
        for (int c = 0; c <= delay; c++) begin
            `CHECK("rd_wait", bus.rsp_valid, 1'b0)
            if (c == delay) begin
                bus.cpl_valid = 1'b1;
                bus.cpl_tid   = TidW'(tid);
                bus.cpl_data  = data;
            end else if (c == stray_at) begin
                bus.cpl_valid = 1'b1;
                bus.cpl_tid   = TidW'(stray_tid);
                bus.cpl_data  = {$urandom, $urandom};
                bump_stray();
            end else begin
                bus.cpl_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.cpl_valid = 1'b0;
        `CHECK("rd_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 3'b100)
        `CHECK("rd_rdata", bus.rsp_rdata, data)
        @(negedge clk);
        `CHECK("rd_idle", {bus.cmd_ready, bus.rsp_valid}, 2'b10)
        `CHECK("rd_stray", bus.stray_cnt, 8'(exp_stray))
    endtask

    initial begin
        int          tid_old;
        int          dly;
        logic        seen;
        logic [15:0] a;
        logic [63:0] d;

        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = 16'h0;
        bus.cmd_wdata = 64'h0;
        bus.cpl_valid = 1'b0;
        bus.cpl_tid   = '0;
        bus.cpl_data  = 64'h0;
        repeat (3) @(negedge clk);

        // Reset state
        n_assert++;
        if ({bus.cmd_ready, bus.req_rd_valid, bus.req_wr_valid, bus.rsp_valid, bus.rsp_err,
             bus.rsp_timeout} !== 6'b100000) begin
            n_fail++;
            $error("FAIL rst_ctrl: got %0b", {bus.cmd_ready, bus.req_rd_valid, bus.req_wr_valid,
                   bus.rsp_valid, bus.rsp_err, bus.rsp_timeout});
        end
        n_assert++;
        if (bus.rsp_rdata !== 64'h0) begin
            n_fail++;
            $error("FAIL rst_rdata: got %0h", bus.rsp_rdata);
        end
        n_assert++;
        if ({bus.req_addr, bus.req_tid, bus.req_data} !== {16'h0, TidW'(0), 64'h0}) begin
            n_fail++;
            $error("FAIL rst_req: addr %0h tid %0h data %0h", bus.req_addr, bus.req_tid,
                   bus.req_data);
        end
        n_assert++;
        if (bus.stray_cnt !== 8'h0) begin
            n_fail++;
            $error("FAIL rst_stray: got %0h", bus.stray_cnt);
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed write, then the plain read
        do_write(16'h0020, 64'hDEAD_BEEF_CAFE_F00D);
        do_read(16'h0000, 1, 64'h1000_0100_0000_0000, -1, 0);

        // Two reads; stray tid 5 during the second wait
        do_read(16'h0040, 2, {$urandom, $urandom}, -1, 0);
        do_read(16'h0042, 3, 64'h0123_4567_89AB_CDEF, 1, 5);
        `CHECK("stray_one", bus.stray_cnt, 8'd1)

`ifdef MMIO_INIT_TIMEOUT_EN
        // Timeout: rsp at T+2+TIMEOUT, late completion counts as stray
        start_read(16'h0100, tid_old);
        seen = 1'b0;
        for (int c = 0; c < int'(TimeoutCyc); c++) begin
            @(negedge clk);
            seen |= bus.rsp_valid;
        end
        `CHECK("to_early", seen, 1'b0)
        @(negedge clk);
        n_assert++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 3'b101) begin
            n_fail++;
            $error("FAIL to_rsp: got %0b", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout});
        end
        n_assert++;
        if (bus.rsp_rdata !== Ones) begin
            n_fail++;
            $error("FAIL to_rdata: got %0h", bus.rsp_rdata);
        end
        @(negedge clk);
        bus.cpl_valid = 1'b1;
        bus.cpl_tid   = TidW'(tid_old);
        bus.cpl_data  = {$urandom, $urandom};
        bump_stray();
        @(negedge clk);
        bus.cpl_valid = 1'b0;
        `CHECK("to_late_stray", bus.stray_cnt, 8'(exp_stray))
`else
        // Without the timeout the read waits until its completion arrives
        start_read(16'h0100, tid_old);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            seen |= bus.rsp_valid;
        end
        `CHECK("nto_wait", seen, 1'b0)
        d = {$urandom, $urandom};
        bus.cpl_valid = 1'b1;
        bus.cpl_tid   = TidW'(tid_old);
        bus.cpl_data  = d;
        @(negedge clk);
        bus.cpl_valid = 1'b0;
        `CHECK("nto_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 3'b100)
        `CHECK("nto_rdata", bus.rsp_rdata, d)
        @(negedge clk);
`endif

        // Misaligned read and write; no TID consumed
        do_misaligned(16'h0021, 1'b0);
        do_misaligned(16'h0033, 1'b1);
        do_read(16'h0008, 1, {$urandom, $urandom}, -1, 0);

        // Reset during WAIT_RD; completion 2 cycles after release is stray
        start_read(16'h0010, tid_old);
        @(negedge clk);
        rst = 1'b1;
        #1;
        `CHECK("mrst_async", {bus.cmd_ready, bus.rsp_valid, bus.stray_cnt}, {2'b10, 8'h0})
        exp_stray = 0;
        exp_tid   = 0;
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                bus.cpl_valid = 1'b1;
                bus.cpl_tid   = TidW'(tid_old);
                bus.cpl_data  = {$urandom, $urandom};
                bump_stray();
            end else begin
                bus.cpl_valid = 1'b0;
            end
            @(negedge clk);
            seen |= bus.rsp_valid;
        end
        bus.cpl_valid = 1'b0;
        n_assert++;
        if (seen !== 1'b0) begin
            n_fail++;
            $error("FAIL mrst_no_rsp: rsp_valid seen after reset");
        end
        `CHECK("mrst_stray", bus.stray_cnt, 8'(exp_stray))
        do_read(16'h0018, 1, {$urandom, $urandom}, -1, 0);

        // Randomized mix of writes, misaligned commands and reads with strays
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            d = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: begin
                    a[0] = 1'b0;
                    do_write(a, d);
                end
                1: begin
                    a[0] = 1'b1;
                    do_misaligned(a, 1'($urandom));
                end
                default: begin
                    a[0] = 1'b0;
                    dly  = int'($urandom_range(1, 6));
                    do_read(a, dly, d, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, dly - 1)) : -1,
                            (exp_tid + 1 + int'($urandom_range(0, TidMod - 2))) % TidMod);
                end
            endcase
        end

        // stray_cnt saturation
        for (int c = 0; c < 270; c++) begin
            bus.cpl_valid = 1'b1;
            bus.cpl_tid   = TidW'($urandom);
            bump_stray();
            @(negedge clk);
        end
        bus.cpl_valid = 1'b0;
        @(negedge clk);
        `CHECK("stray_sat", bus.stray_cnt, 8'(exp_stray))
        `CHECK("stray_sat_255", bus.stray_cnt, 8'hFF)

        // Enough reads to wrap the TID counter
        for (int i = 0; i < TidMod + 8; i++) begin
            do_read(16'({$urandom} << 1), 1, {$urandom, $urandom}, -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
